// File: rtl/mat_mul_core.sv
// rtl/mat_mul_core.sv - fully pipelined signed NxN integer matrix multiplier
//
// Stage 1 registers every product term; each following stage is one
// registered level of a binary adder tree per output element. The last
// tree level drives result directly. A parallel shift register carries
// valid_in alongside the data so valid_out lines up with result.
module mat_mul_core #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int N     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cen,
    input  logic                             valid_in,
    input  logic [N-1:0][N-1:0][W_IN-1:0]    matrix_1,
    input  logic [N-1:0][N-1:0][W_IN-1:0]    matrix_2,
    output logic [N-1:0][N-1:0][W_OUT-1:0]   result,
    output logic                             valid_out
);

    // Adder-tree depth; N = 1 has no tree and the product register is the output.
    localparam int LVLS = $clog2(N);
    localparam int LAT  = LVLS + 1;

    // Number of operands entering tree level l (ceil(N / 2^l)).
    function automatic int level_count(input int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: one multiplier per (i,j,k) term
    // ------------------------------------------------------------------
    logic signed [W_OUT-1:0] prod_d [N][N][N];
    logic signed [W_OUT-1:0] prod_q [N][N][N];

    // Full-precision signed product, sign-extended to the accumulator width.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++) begin
                    prod_d[i][j][k] = W_OUT'((2*W_IN)'($signed(matrix_1[i][k]))
                                           * (2*W_IN)'($signed(matrix_2[k][j])));
                end
            end
        end
    end

    // Product registers: cleared by reset, frozen while cen is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    for (int k = 0; k < N; k++) begin
                        prod_q[i][j][k] <= '0;
                    end
                end
            end
        end else if (cen) begin
            prod_q <= prod_d;
        end
    end

    // ------------------------------------------------------------------
    // Stages 2..LAT: registered binary adder tree per output element
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        localparam int CI = level_count(l);
        localparam int CO = level_count(l + 1);

        logic signed [W_OUT-1:0] src   [N][N][CI];
        logic signed [W_OUT-1:0] sum_d [N][N][CO];
        logic signed [W_OUT-1:0] sum_q [N][N][CO];

        for (genvar i = 0; i < N; i++) begin : g_row
            for (genvar j = 0; j < N; j++) begin : g_col
                // Level inputs: the product terms, or the previous level's sums.
                for (genvar m = 0; m < CI; m++) begin : g_src
                    if (l == 0) begin : g_from_prod
                        assign src[i][j][m] = prod_q[i][j][m];
                    end else begin : g_from_lvl
                        assign src[i][j][m] = g_lvl[l-1].sum_q[i][j][m];
                    end
                end
                // Pairwise sums; an unpaired last operand passes through as-is.
                for (genvar o = 0; o < CO; o++) begin : g_sum
                    if (2*o + 1 < CI) begin : g_pair
                        assign sum_d[i][j][o] = src[i][j][2*o] + src[i][j][2*o+1];
                    end else begin : g_pass
                        assign sum_d[i][j][o] = src[i][j][2*o];
                    end
                end
            end
        end

        // Tree level register: sums wrap modulo 2^W_OUT, no saturation.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        for (int o = 0; o < CO; o++) begin
                            sum_q[i][j][o] <= '0;
                        end
                    end
                end
            end else if (cen) begin
                sum_q <= sum_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping: last pipeline register drives result directly
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_out_row
        for (genvar j = 0; j < N; j++) begin : g_out_col
            if (LVLS == 0) begin : g_no_tree
                assign result[i][j] = prod_q[i][j][0];
            end else begin : g_tree
                assign result[i][j] = g_lvl[LVLS-1].sum_q[i][j][0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid chain, LAT deep, advanced together with the datapath
    // ------------------------------------------------------------------
    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;

    assign vld_d     = LAT'({vld_q, valid_in});
    assign valid_out = vld_q[LAT-1];

    // Valid shift register: shifts only on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (cen) begin
            vld_q <= vld_d;
        end
    end

endmodule

// File: tb/tb_mat_mul_core.sv
// tb/tb_mat_mul_core.sv - self-checking bench for mat_mul_core with scoreboard
module tb_mat_mul_core;

    localparam int N   = 8;
    localparam int LAT = 4;

    typedef logic [N-1:0][N-1:0][31:0] mat_t;
    typedef logic [N-1:0][N-1:0][7:0]  opd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b0;
    logic valid_in = 1'b0;
    opd_t m1;
    opd_t m2;
    mat_t res;
    logic vout;

    logic [4:0][4:0][7:0]  sa, sb;
    logic [2:0][2:0][7:0]  s3a, s3b;
    logic [0:0][0:0][7:0]  s1a, s1b;
    logic [0:0][0:0][15:0] r1;
    logic [2:0][2:0][15:0] r3;
    logic [4:0][4:0][15:0] r5;
    logic v1, v3, v5;

    int checks = 0;
    int passed = 0;
    int en_edges = 0;
    mat_t exp_q[$];
    int   exp_e[$];

    always #5 clk = ~clk;

    mat_mul_core #(.W_IN(8), .W_OUT(32), .N(8)) dut (
        .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in),
        .matrix_1(m1), .matrix_2(m2), .result(res), .valid_out(vout));
    mat_mul_core #(.W_IN(8), .W_OUT(16), .N(1)) dut1 (
        .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in),
        .matrix_1(s1a), .matrix_2(s1b), .result(r1), .valid_out(v1));
    mat_mul_core #(.W_IN(8), .W_OUT(16), .N(3)) dut3 (
        .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in),
        .matrix_1(s3a), .matrix_2(s3b), .result(r3), .valid_out(v3));
    mat_mul_core #(.W_IN(8), .W_OUT(16), .N(5)) dut5 (
        .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in),
        .matrix_1(sa), .matrix_2(sb), .result(r5), .valid_out(v5));

    // Smaller sweep instances see the top-left corner of the 5x5 operands.
    always_comb begin
        s3a = '0;
        s3b = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s3a[i][j] = sa[i][j];
                s3b[i][j] = sb[i][j];
            end
        end
        s1a[0][0] = sa[0][0];
        s1b[0][0] = sb[0][0];
    end

    function automatic mat_t golden(input opd_t a, input opd_t b);
        mat_t r;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) begin
                    s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                end
                r[i][j] = 32'(s);
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] golden_s(input int n, input int i, input int j,
                                             input logic [4:0][4:0][7:0] a,
                                             input logic [4:0][4:0][7:0] b);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        end
        return 16'(s);
    endfunction

    function automatic int first_diff(input mat_t a, input mat_t b);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (a[i][j] !== b[i][j]) return i * N + j;
            end
        end
        return 0;
    endfunction

    function automatic opd_t rand_opd();
        opd_t r;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                r[i][j] = 8'($urandom_range(0, 255));
            end
        end
        return r;
    endfunction

    // One clock: drive cen/valid_in, record the expectation on enabled edges, sample at +1.
    task automatic step(input logic c, input logic v);
        cen      = c;
        valid_in = v;
        @(posedge clk);
        if (c && !rst) begin
            en_edges++;
            if (v) begin
                exp_q.push_back(golden(m1, m2));
                exp_e.push_back(en_edges + LAT - 1);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m1 = '0; m2 = '0; sa = '0; sb = '0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (res !== '0 || vout !== 1'b0) $display("FAIL reset_main: result[0][0]=%0d valid_out=%b, required 0 and 0", res[0][0], vout);
        else passed++;
        checks++;
        if (r1 !== '0 || r3 !== '0 || r5 !== '0 || {v1, v3, v5} !== 3'b000)
            $display("FAIL reset_sweep: valids=%b r5[0][0]=%0d, required 000 and 0", {v1, v3, v5}, r5[0][0]);
        else passed++;
        cen = 1'b1; valid_in = 1'b1; m1 = rand_opd(); m2 = rand_opd();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (res !== '0 || vout !== 1'b0) $display("FAIL reset_held: result[0][0]=%0d valid_out=%b, required 0 and 0", res[0][0], vout);
        else passed++;
        #2;
        cen = 1'b0; valid_in = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        mat_t k_exp;
        m1 = '0;
        for (int i = 0; i < N; i++) begin
            m1[i][i] = 8'd1;
            for (int j = 0; j < N; j++) begin
                m2[i][j]    = 8'(i * N + j);
                k_exp[i][j] = 32'(i * N + j);
            end
        end
        for (int c = 0; c < LAT; c++) begin
            step(1'b1, c == 0);
            if (c < LAT - 1) begin
                checks++;
                if (vout !== 1'b0) $display("FAIL identity_early_valid: edge %0d valid_out=%b, required 0", c + 1, vout);
                else passed++;
            end else begin
                mat_t e;
                int   t;
                checks++;
                if (vout !== 1'b1 || exp_q.size() == 0) $display("FAIL identity_valid: valid_out=%b, required 1", vout);
                else begin
                    passed++;
                    e = exp_q.pop_front();
                    t = exp_e.pop_front();
                    checks++;
                    if (res !== e || en_edges != t)
                        $display("FAIL identity_sb: elem %0d got %0d exp %0d, edge %0d exp %0d",
                                 first_diff(res, e), res[first_diff(res, e)/N][first_diff(res, e)%N],
                                 e[first_diff(res, e)/N][first_diff(res, e)%N], en_edges, t);
                    else passed++;
                end
                checks++;
                if (res !== k_exp)
                    $display("FAIL identity_const: elem %0d got %0d required %0d", first_diff(res, k_exp),
                             res[first_diff(res, k_exp)/N][first_diff(res, k_exp)%N],
                             k_exp[first_diff(res, k_exp)/N][first_diff(res, k_exp)%N]);
                else passed++;
            end
        end
    endtask

    task automatic test_extremes();
        int nout;
        nout = 0;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    m1[i][j] = 8'h80;
                    m2[i][j] = (c == 0) ? 8'h80 : 8'h7f;
                end
            end
            step(1'b1, c < 2);
            if (vout === 1'b1 && exp_q.size() > 0) begin
                mat_t e;
                mat_t kc;
                int   t;
                e = exp_q.pop_front();
                t = exp_e.pop_front();
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        kc[i][j] = (nout == 0) ? 32'sd131072 : -32'sd130048;
                    end
                end
                checks++;
                if (res !== e || en_edges != t)
                    $display("FAIL extremes_sb: out %0d [0][0] got %0d exp %0d, edge %0d exp %0d", nout, $signed(res[0][0]), $signed(e[0][0]), en_edges, t);
                else passed++;
                checks++;
                if (res !== kc)
                    $display("FAIL extremes_const: out %0d elem %0d got %0d required %0d", nout, first_diff(res, kc),
                             $signed(res[first_diff(res, kc)/N][first_diff(res, kc)%N]), $signed(kc[0][0]));
                else passed++;
                nout++;
            end
        end
        checks++;
        if (nout != 2) $display("FAIL extremes_count: got %0d outputs, required 2", nout);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int nout;
        int bad;
        nout = 0;
        bad  = 0;
        void'($urandom(56));
        for (int c = 0; c < 13; c++) begin
            if (c < 10) begin
                m1 = rand_opd();
                m2 = rand_opd();
            end
            step(1'b1, c < 10);
            if (c >= LAT - 1) begin
                checks++;
                if (vout !== 1'b1) $display("FAIL b2b_valid: cycle %0d valid_out=%b, required 1", c, vout);
                else passed++;
            end
            if (vout === 1'b1 && exp_q.size() > 0) begin
                mat_t e;
                int   t;
                e = exp_q.pop_front();
                t = exp_e.pop_front();
                checks++;
                if (res !== e || en_edges != t)
                    $display("FAIL b2b_sb: out %0d elem %0d got %0d exp %0d, edge %0d exp %0d", nout, first_diff(res, e),
                             $signed(res[first_diff(res, e)/N][first_diff(res, e)%N]),
                             $signed(e[first_diff(res, e)/N][first_diff(res, e)%N]), en_edges, t);
                else passed++;
                nout++;
            end
        end
        checks++;
        if (nout != 10) $display("FAIL b2b_count: got %0d outputs, required 10", nout);
        else passed++;
    endtask

    task automatic test_cen();
        mat_t snap;
        mat_t e;
        m1 = rand_opd();
        m2 = rand_opd();
        e  = '0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        snap = res;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1);
            checks++;
            if (vout !== 1'b0 || res !== snap)
                $display("FAIL cen_stall_frozen: cycle %0d valid_out=%b [0][0] got %0d required %0d", c, vout, res[0][0], snap[0][0]);
            else passed++;
        end
        step(1'b1, 1'b0);
        checks++;
        if (vout !== 1'b0) $display("FAIL cen_early_valid: valid_out=%b, required 0", vout);
        else passed++;
        step(1'b1, 1'b0);
        checks++;
        if (vout !== 1'b1 || exp_q.size() == 0) $display("FAIL cen_valid: valid_out=%b, required 1", vout);
        else begin
            int t;
            passed++;
            e = exp_q.pop_front();
            t = exp_e.pop_front();
            checks++;
            if (res !== e || en_edges != t)
                $display("FAIL cen_sb: elem %0d got %0d exp %0d, edge %0d exp %0d", first_diff(res, e),
                         $signed(res[first_diff(res, e)/N][first_diff(res, e)%N]),
                         $signed(e[first_diff(res, e)/N][first_diff(res, e)%N]), en_edges, t);
            else passed++;
        end
        m1 = rand_opd();
        step(1'b0, 1'b0);
        checks++;
        if (vout !== 1'b1 || res !== e)
            $display("FAIL cen_hold_output: valid_out=%b [0][0] got %0d required %0d", vout, res[0][0], e[0][0]);
        else passed++;
        step(1'b1, 1'b0);
        checks++;
        if (vout !== 1'b0) $display("FAIL cen_after_valid: valid_out=%b, required 0", vout);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        m1 = rand_opd(); m2 = rand_opd();
        step(1'b1, 1'b1);
        m1 = rand_opd(); m2 = rand_opd();
        step(1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (res !== '0 || vout !== 1'b0) $display("FAIL rstmid_immediate: result[0][0]=%0d valid_out=%b, required 0 and 0", res[0][0], vout);
        else passed++;
        exp_q.delete();
        exp_e.delete();
        cen = 1'b1; valid_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (res !== '0 || vout !== 1'b0) $display("FAIL rstmid_held: result[0][0]=%0d valid_out=%b, required 0 and 0", res[0][0], vout);
        else passed++;
        #2 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0);
            if (vout !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) $display("FAIL rstmid_stale: %0d cycles with valid_out=1, required 0", stale);
        else passed++;
        m1 = rand_opd(); m2 = rand_opd();
        for (int c = 0; c < LAT; c++) begin
            step(1'b1, c == 0);
        end
        checks++;
        if (vout !== 1'b1 || exp_q.size() == 0) $display("FAIL rstmid_new_valid: valid_out=%b, required 1", vout);
        else begin
            mat_t e;
            int   t;
            passed++;
            e = exp_q.pop_front();
            t = exp_e.pop_front();
            checks++;
            if (res !== e || en_edges != t)
                $display("FAIL rstmid_sb: elem %0d got %0d exp %0d, edge %0d exp %0d", first_diff(res, e),
                         $signed(res[first_diff(res, e)/N][first_diff(res, e)%N]),
                         $signed(e[first_diff(res, e)/N][first_diff(res, e)%N]), en_edges, t);
            else passed++;
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_sweep();
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    sa[i][j] = (round == 0) ? 8'($urandom_range(0, 255)) : 8'h80;
                    sb[i][j] = (round == 0) ? 8'($urandom_range(0, 255)) : 8'h80;
                end
            end
            cen = 1'b1;
            valid_in = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                valid_in = 1'b0;
                checks++;
                if ({v1, v3, v5} !== {k == 1, k == 3, k == 4})
                    $display("FAIL sweep_valid: round %0d edge %0d valids(N1,N3,N5)=%b required %b", round, k, {v1, v3, v5}, {k == 1, k == 3, k == 4});
                else passed++;
                if (k == 1) begin
                    logic [15:0] e1;
                    e1 = (round == 0) ? golden_s(1, 0, 0, sa, sb) : 16'd16384;
                    checks++;
                    if (r1[0][0] !== e1) $display("FAIL sweep_n1: round %0d got %0d required %0d", round, $signed(r1[0][0]), $signed(e1));
                    else passed++;
                end
                if (k == 3) begin
                    int bi;
                    bi = -1;
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            logic [15:0] e3;
                            e3 = (round == 0) ? golden_s(3, i, j, sa, sb) : 16'hC000;
                            if (r3[i][j] !== e3 && bi < 0) bi = i * 3 + j;
                        end
                    end
                    checks++;
                    if (bi >= 0) $display("FAIL sweep_n3: round %0d elem %0d got %0d required %0d", round, bi,
                                          $signed(r3[bi/3][bi%3]),
                                          (round == 0) ? $signed(golden_s(3, bi/3, bi%3, sa, sb)) : -16384);
                    else passed++;
                end
                if (k == 4) begin
                    int bi;
                    bi = -1;
                    for (int i = 0; i < 5; i++) begin
                        for (int j = 0; j < 5; j++) begin
                            logic [15:0] e5;
                            e5 = (round == 0) ? golden_s(5, i, j, sa, sb) : 16'd16384;
                            if (r5[i][j] !== e5 && bi < 0) bi = i * 5 + j;
                        end
                    end
                    checks++;
                    if (bi >= 0) $display("FAIL sweep_n5: round %0d elem %0d got %0d required %0d", round, bi,
                                          $signed(r5[bi/5][bi%5]),
                                          (round == 0) ? $signed(golden_s(5, bi/5, bi%5, sa, sb)) : 16384);
                    else passed++;
                end
            end
        end
        cen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_extremes();
        test_back_to_back();
        test_cen();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mat_mul_core.md
# mat_mul_core

Fully pipelined, signed, integer N×N matrix multiplier for the SIMD processor datapath. Each cycle it accepts two complete N×N operand matrices and produces their product matrix a fixed number of cycles later. One multiplier per (i,j,k) term, followed by a registered adder tree per output element. The block sustains one matrix product per enabled clock.

## Interface

Parameters:
- W_IN, default 8: width of each signed input element.
- W_OUT, default 32: width of each signed result element; W_OUT ≥ 2·W_IN.
- N, default 8: matrix dimension, N ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all pipeline state.
- cen  in  1  clock enable; when 0 every pipeline register, including the valid chain, holds its value.
- valid_in  in  1  marks matrix_1/matrix_2 as a valid operand pair this cycle.
- matrix_1  in  N·N·W_IN  signed packed [N-1:0][N-1:0][W_IN-1:0]; element [i][j] is row i, column j.
- matrix_2  in  N·N·W_IN  signed, same layout.
- result  out  N·N·W_OUT  signed packed [N-1:0][N-1:0][W_OUT-1:0].
- valid_out  out  1  result holds the product of the pair presented with valid_in = 1, LAT enabled cycles earlier.

## Operation

- result[i][j] = Σ_{k=0..N-1} matrix_1[i][k] · matrix_2[k][j], with all elements treated as two's-complement signed.
- Products are computed at full 2·W_IN signed precision and sign-extended to W_OUT.
- Summation is done in W_OUT bits and wraps modulo 2^W_OUT. There is no saturation and no overflow flag.
- Stage 1: all N³ products registered (product[i][j][k]).
- Stages 2..LAT: a binary adder tree per (i,j) with ceil(log2 N) levels, each level registered.
  - When a level has an odd operand count, the unpaired operand passes through a register unchanged, equivalent to padding with zero.
- The last adder-tree register drives result directly, with no extra output register.
- For N = 1 there is no adder level, and result is the registered sign-extended product.
- valid_out is produced by a LAT-deep shift register of valid_in, advanced only when cen = 1.
- Datapath registers load regardless of valid_in. Result contents are meaningful only while valid_out = 1.

## Timing

- LAT = $clog2(N) + 1; for N = 8, LAT = 4.
- Operands present before rising edge E (with cen = 1 on each edge) appear on result after edge E + LAT − 1. They are stable from just after that edge.
- Fully pipelined: a new operand pair may be presented every cycle, with no stalls and no backpressure.
- cen = 0 on an edge: no register changes. Latency counts enabled edges only.
- Reset (asynchronous, any time, including mid-pipeline): result = 0, valid_out = 0, all product/tree/valid registers = 0 immediately. In-flight operations are discarded.
- The first valid output after reset release comes LAT enabled edges after the first sampled valid_in = 1.
- cen and valid_in are ignored while rst = 1.

## Test plan

- Identity: matrix_1 = I (diagonal 1), matrix_2[i][j] = i·N + j, cen = valid_in = 1 → after 4 edges result[i][j] = i·8 + j, valid_out = 1.
- Signed extremes: all matrix_1 and matrix_2 elements = −128 (8'h80) → every result element = 8·16384 = 131072. Then matrix_1 all −128 and matrix_2 all 127 → every element = −130048.
- Random back-to-back: 10 random operand pairs (seed 56, 8-bit elements), one per cycle → each result matches the golden signed matrix product exactly 4 edges after its input edge, and valid_out stays high.
- Clock enable: present pair A, deassert cen for 3 cycles mid-pipeline, then reassert → A's product appears after 4 enabled edges, and result/valid_out are frozen during the stall.
- Reset mid-operation: pulse rst asynchronously between edges with 2 pairs in flight → result = 0 and valid_out = 0 immediately. No stale product appears after release; a new pair yields its correct product 4 edges later.
- Parameter sweep: N = 1, 3, 5 with W_OUT = 16 → LAT = 1, 3, 4. The odd-count tree pass-through gives exact sums. A wrapping case (W_IN = 8, W_OUT = 16, N = 3, all elements −128) gives 49152 mod 2^16 read as signed = −16384.
